// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, commit and free-list signals between the core and the reorder buffer.
// The master modport is the core side; the slave modport is the reorder buffer.
interface reorder_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int AREG_W = 3,
  parameter int PREG_W = 6
);
  localparam int TAG_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_dest;
  logic [AREG_W-1:0] alloc_areg;
  logic [PREG_W-1:0] alloc_preg;
  logic [PREG_W-1:0] alloc_old_preg;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic              flush;
  logic              commit_valid;
  logic              commit_has_dest;
  logic [AREG_W-1:0] commit_areg;
  logic [PREG_W-1:0] commit_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic [TAG_W:0]    count;

  modport master (
    output alloc_valid, alloc_has_dest, alloc_areg, alloc_preg, alloc_old_preg,
    output wb_valid, wb_tag, flush,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_has_dest, commit_areg, commit_preg,
    input  free_valid, free_preg, count
  );

  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_areg, alloc_preg, alloc_old_preg,
    input  wb_valid, wb_tag, flush,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_has_dest, commit_areg, commit_preg,
    output free_valid, free_preg, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one alloc, one writeback and one commit per cycle; commit is
// combinational from registered state (wb -> commit next cycle); alloc refused only when full.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int AREG_W = 3,
  parameter int PREG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   occ;

  logic   full;
  logic   alloc_fire;
  logic   wb_fire;
  logic   commit_fire;
  entry_t head_ent;

  assign head_ent = ent[head];
  assign full     = (occ == FULL_CNT);

  // Fullness is judged on registered occupancy, so a same-cycle commit never frees a slot early.
  assign alloc_fire  = rob.alloc_valid & ~full & ~rob.flush;
  assign wb_fire     = rob.wb_valid & ent[rob.wb_tag].valid & ~rob.flush;
  assign commit_fire = head_ent.valid & head_ent.done & ~rob.flush;

  assign rob.alloc_ready     = rst | ~full;
  assign rob.alloc_tag       = rst ? '0 : tail;
  assign rob.count           = rst ? '0 : occ;
  assign rob.commit_valid    = commit_fire & ~rst;
  assign rob.commit_has_dest = rst ? 1'b0 : head_ent.has_dest;
  assign rob.commit_areg     = rst ? '0 : head_ent.areg;
  assign rob.commit_preg     = rst ? '0 : head_ent.preg;
  assign rob.free_valid      = commit_fire & ~rst & head_ent.has_dest;
  assign rob.free_preg       = rst ? '0 : head_ent.old_preg;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (rob.flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      // Tail slot is invalid whenever alloc fires, so wb_fire can never target it.
      if (alloc_fire) begin
        ent[tail].valid    <= 1'b1;
        ent[tail].done     <= 1'b0;
        ent[tail].has_dest <= rob.alloc_has_dest;
        ent[tail].areg     <= rob.alloc_areg;
        ent[tail].preg     <= rob.alloc_preg;
        ent[tail].old_preg <= rob.alloc_old_preg;
        tail               <= tail + 1'b1;
      end
      if (wb_fire) begin
        ent[rob.wb_tag].done <= 1'b1;
      end
      if (commit_fire) begin
        ent[head].valid <= 1'b0;
        ent[head].done  <= 1'b0;
        head            <= head + 1'b1;
      end
      occ <= occ + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed test-plan sequences followed by random traffic, scored against a queue model of the ROB.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reorder_buffer_if #(.DEPTH(DEPTH), .AREG_W(3), .PREG_W(6)) bus ();

  reorder_buffer #(.DEPTH(DEPTH), .AREG_W(3), .PREG_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .rob (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit hd;
    int areg;
    int preg;
    int old;
    bit done;
  } ment_t;

  ment_t q[$];
  int    next_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    bit    exp_ready;
    bit    exp_commit;
    ment_t h;
    ment_t n;
    if (rst) begin
      chk("rst_alloc_ready", bus.alloc_ready, 1);
      chk("rst_alloc_tag", bus.alloc_tag, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_commit_valid", bus.commit_valid, 0);
      chk("rst_free_valid", bus.free_valid, 0);
      chk("rst_commit_has_dest", bus.commit_has_dest, 0);
      chk("rst_commit_areg", bus.commit_areg, 0);
      chk("rst_commit_preg", bus.commit_preg, 0);
      chk("rst_free_preg", bus.free_preg, 0);
      q.delete();
      next_tag = 0;
    end else begin
      exp_ready  = (q.size() != DEPTH);
      exp_commit = (q.size() > 0) && q[0].done && !bus.flush;
      chk("alloc_ready", bus.alloc_ready, exp_ready);
      chk("alloc_tag", bus.alloc_tag, next_tag);
      chk("count", bus.count, q.size());
      chk("commit_valid", bus.commit_valid, exp_commit);
      if (exp_commit) begin
        h = q[0];
        chk("commit_has_dest", bus.commit_has_dest, h.hd);
        chk("commit_areg", bus.commit_areg, h.areg);
        chk("commit_preg", bus.commit_preg, h.preg);
        chk("free_valid", bus.free_valid, h.hd);
        if (h.hd) chk("free_preg", bus.free_preg, h.old);
      end else begin
        chk("free_valid_idle", bus.free_valid, 0);
      end
      if (bus.flush) begin
        q.delete();
        next_tag = 0;
      end else begin
        if (bus.wb_valid) begin
          foreach (q[i]) if (q[i].tag == int'(bus.wb_tag)) q[i].done = 1'b1;
        end
        if (exp_commit) void'(q.pop_front());
        if (bus.alloc_valid && exp_ready) begin
          n.tag  = next_tag;
          n.hd   = bus.alloc_has_dest;
          n.areg = bus.alloc_areg;
          n.preg = bus.alloc_preg;
          n.old  = bus.alloc_old_preg;
          n.done = 1'b0;
          q.push_back(n);
          next_tag = (next_tag + 1) % DEPTH;
        end
      end
    end
  end

  task automatic drive(input bit av, input bit hd, input int ar, input int pr, input int op,
                       input bit wv, input int wt, input bit fl);
    bus.alloc_valid    = av;
    bus.alloc_has_dest = hd;
    bus.alloc_areg     = 3'(ar);
    bus.alloc_preg     = 6'(pr);
    bus.alloc_old_preg = 6'(op);
    bus.wb_valid       = wv;
    bus.wb_tag         = 4'(wt);
    bus.flush          = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.alloc_valid = 0; bus.alloc_has_dest = 0; bus.alloc_areg = 0; bus.alloc_preg = 0;
    bus.alloc_old_preg = 0; bus.wb_valid = 0; bus.wb_tag = 0; bus.flush = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill to 16, a 17th request is refused; then head done + alloc while full.
    for (int i = 0; i < 17; i++) drive(1, 1, i % 8, 20 + i, 40 + i, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 1, 7, 50, 51, 0, 0, 0);
    drive(1, 1, 7, 50, 51, 0, 0, 0);
    for (int i = 1; i < 16; i++) drive(0, 0, 0, 0, 0, 1, i, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Out-of-order completion retires in order.
    do_flush();
    drive(1, 1, 1, 10, 4, 0, 0, 0);
    drive(1, 1, 2, 11, 5, 0, 0, 0);
    drive(1, 1, 3, 12, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 2, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);

    // No destination: commits without a free-list push.
    drive(1, 0, 5, 30, 31, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 3, 0);
    idle(2);

    // Flush with a done head suppresses the commit; stale wb is ignored afterwards.
    do_flush();
    for (int i = 0; i < 5; i++) drive(1, 1, i, 33 + i, 1 + i, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    do_flush();
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 3, 0);
    idle(2);

    // Writeback in the allocation cycle of the same tag is dropped.
    drive(1, 1, 6, 60, 61, 1, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Random traffic, with an occasional flush and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
      drive(($urandom % 4) != 0, $urandom % 2, $urandom % 8, $urandom % 64, $urandom % 64,
            ($urandom % 3) != 0, $urandom_range(0, DEPTH - 1), ($urandom % 64) == 0);
    end
    for (int i = 0; i < 2 * DEPTH; i++) drive(0, 0, 0, 0, 0, 1, i % DEPTH, 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer for the out-of-order core.
- Dispatch allocates one entry per cycle in program order.
- Execution units mark entries complete by tag.
- The head entry retires when complete.
- Each retirement carrying a destination emits the superseded physical register on a push-style port, which drives the push/in side of the physical-register free-list circular queue directly.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
AREG_W, 3, architectural register index width
PREG_W, 6, physical register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry available (not full)
alloc_has_dest  in  1  instruction writes a register
alloc_areg  in  AREG_W  architectural destination
alloc_preg  in  PREG_W  newly mapped physical destination
alloc_old_preg  in  PREG_W  previous mapping of alloc_areg
alloc_tag  out  log2(DEPTH)  index given to the allocating instruction (= tail)
wb_valid  in  1  execution unit completes an instruction
wb_tag  in  log2(DEPTH)  entry completed
flush  in  1  squash all in-flight entries
commit_valid  out  1  head entry retires this cycle
commit_has_dest  out  1  retiring entry writes a register
commit_areg  out  AREG_W  retiring architectural register
commit_preg  out  PREG_W  retiring physical register
free_valid  out  1  push to free list (= commit_valid & commit_has_dest)
free_preg  out  PREG_W  old_preg of retiring entry
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset and clock: one clock `clk`; `rst` is synchronous and active-high.
- Per-entry state: valid, done, has_dest, areg, preg, old_preg.
- Pointers and count: head/tail pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0. count tracks occupancy: full when count == DEPTH, empty when count == 0.
- Reset (`rst` = 1 at an edge):
  - all valid/done cleared; head = tail = 0; count = 0.
  - outputs while in reset and until the first alloc: alloc_ready = 1, alloc_tag = 0, commit_valid = 0, free_valid = 0, commit_* / free_preg = 0, count = 0.
  - `rst` has priority over every other input.
- alloc_ready = (count != DEPTH), combinational from registered state only. It never depends on a same-cycle commit, so when full, no alloc occurs even if the head commits that cycle.
- Allocate:
  - Fires when alloc_valid & alloc_ready.
  - At the edge: entry[tail] is written with valid = 1, done = 0 and the alloc fields; tail increments.
  - alloc_tag is valid in the same cycle as the request.
- Writeback:
  - wb_valid sets entry[wb_tag].done = 1 at the edge, only if entry[wb_tag].valid is already 1.
  - Writeback to an invalid entry, or to the entry being allocated in the same cycle, is ignored.
  - Writeback to an already-done entry has no effect.
- Commit:
  - commit_valid = entry[head].valid & entry[head].done & ~flush, combinational.
  - commit_has_dest, commit_areg and commit_preg come from entry[head]; free_preg = entry[head].old_preg.
  - When commit_valid = 1, at the edge entry[head].valid/done are cleared and head increments.
  - At most one commit per cycle. No external stall: consumers must accept every commit.
- Latency:
  - Alloc at edge N -> earliest wb at edge N+1.
  - wb at edge M -> commit_valid high in the cycle after M.
  - No wb-to-commit bypass.
- Simultaneous alloc + commit: count unchanged; both pointers advance.
- Simultaneous alloc + wb + commit on different entries: all three take effect.
- Single entry (count == 1, head == tail-1): alloc and commit in the same cycle are legal.
- Flush:
  - At the edge: all valid/done cleared; head = tail = 0; count = 0.
  - Alloc and wb in the flush cycle are discarded.
  - commit_valid and free_valid are forced to 0 during the flush cycle.
  - Flush with `rst` behaves as `rst`.
- Outputs derived from invalid entries (commit_* / free_preg when commit_valid = 0) are don't-care, except during reset, where they are 0.

Test Plan:
- Reset, then 16 allocs with no wb -> tags 0..15, count 16, alloc_ready = 0 after the 16th. A 17th alloc_valid is ignored and count stays 16.
- Alloc 3 (areg 1/2/3, preg 10/11/12, old 4/5/6, all has_dest); wb tags 2, 1, 0 in successive cycles -> nothing commits until tag 0 is done. Then tags 0, 1, 2 commit on three consecutive cycles with free_preg 4, 5, 6.
- Alloc with has_dest = 0, then wb -> commit_valid = 1, free_valid = 0.
- Full buffer with a done head: alloc_valid + commit in the same cycle -> commit occurs, alloc refused, count 15. Next cycle the alloc is accepted with alloc_tag = 0 (tail wrap) and count returns to 16.
- 5 entries in flight, head done, flush asserted -> commit_valid = 0 that cycle; next cycle count = 0, alloc_tag = 0. A subsequent wb to old tag 3 is ignored and produces no commit.
- Alloc in the same cycle as wb to that tag -> done stays 0 and there is no commit. A later wb completes the entry normally.
